// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file for the 5-stage MIPS pipeline.
// Optional macro WB_BYPASS_EN: same-cycle write-before-read forwarding on both read ports.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h000003FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_alu_out,
    input  logic [31:0] wb_mem_data,
    input  logic [4:0]  wb_rd,
    input  logic [1:0]  wb_mem_to_reg,
    input  logic        wb_reg_write,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic [31:0] commit_count
);

    logic [31:0] regs_q [32];
    logic [31:0] commit_count_q;
    logic [31:0] commit_count_d;
    logic        commit_s;

    // Selector 2'b11 is reserved and falls back to the ALU result.
    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] mem,
                                              input logic [31:0] pc);
        logic [31:0] val;
        case (sel)
            2'b00:   val = alu;
            2'b01:   val = mem;
            2'b10:   val = pc + 32'd4;
            default: val = alu;
        endcase
        return val;
    endfunction

    // Write-back value, commit qualification and forwarding tap.
    always_comb begin
        fwd_data  = wb_select(wb_mem_to_reg, wb_alu_out, wb_mem_data, wb_pc);
        commit_s  = wb_reg_write && (wb_rd != 5'd0);
        fwd_valid = commit_s;
        if (commit_s) begin
            fwd_rd = wb_rd;
        end else begin
            fwd_rd = 5'd0;
        end
    end

    // Commit counter next state; wraps naturally at 2^32.
    always_comb begin
        if (commit_s) begin
            commit_count_d = commit_count_q + 32'd1;
        end else begin
            commit_count_d = commit_count_q;
        end
    end

    // Register array and counter; reset restores $sp and clears everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? SP_INIT : 32'd0;
            end
            commit_count_q <= 32'd0;
        end else begin
            if (commit_s) begin
                regs_q[wb_rd] <= fwd_data;
            end
            commit_count_q <= commit_count_d;
        end
    end

    assign commit_count = commit_count_q;

    // Read port A; $0 is hardwired to zero.
    always_comb begin
        rs_data = 32'd0;
        if (rs_addr == 5'd0) begin
            rs_data = 32'd0;
`ifdef WB_BYPASS_EN
        end else if (commit_s && (rs_addr == wb_rd)) begin
            rs_data = fwd_data;
`endif
        end else begin
            rs_data = regs_q[rs_addr];
        end
    end

    // Read port B; same rules as port A.
    always_comb begin
        rt_data = 32'd0;
        if (rt_addr == 5'd0) begin
            rt_data = 32'd0;
`ifdef WB_BYPASS_EN
        end else if (commit_s && (rt_addr == wb_rd)) begin
            rt_data = fwd_data;
`endif
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow the build's WB_BYPASS_EN setting.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] wb_pc;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] commit_count;

    int tests_run_r;
    int tests_failed_r;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .wb_pc         (wb_pc),
        .wb_alu_out    (wb_alu_out),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .commit_count  (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run_r++;
        if (act !== exp) begin
            tests_failed_r++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one WB instruction after the falling edge, then let it commit on the next rising edge.
    task automatic wb_issue(input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        @(negedge clk);
        wb_rd         = rd;
        wb_mem_to_reg = sel;
        wb_alu_out    = alu;
        wb_mem_data   = mem;
        wb_pc         = pc;
        wb_reg_write  = 1'b1;
        #1;
    endtask

    task automatic wb_commit();
        @(posedge clk);
        #1;
        wb_reg_write = 1'b0;
        #1;
    endtask

    initial begin
        tests_run_r    = 0;
        tests_failed_r = 0;
        reset         = 1'b1;
        wb_pc         = 32'd0;
        wb_alu_out    = 32'd0;
        wb_mem_data   = 32'd0;
        wb_rd         = 5'd0;
        wb_mem_to_reg = 2'b00;
        wb_reg_write  = 1'b0;
        rs_addr       = 5'd29;
        rt_addr       = 5'd5;
        #12;
        check_val("rst_sp", rs_data, 32'h000003FC);
        check_val("rst_r5", rt_data, 32'd0);
        check_val("rst_cnt", commit_count, 32'd0);
        check_val("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU, memory and link write-back to $8
        wb_issue(5'd8, 2'b00, 32'h12345678, 32'h0BAD0BAD, 32'h00001000);
        check_val("alu_fwd_data", fwd_data, 32'h12345678);
        check_val("alu_fwd_rd", {27'd0, fwd_rd}, 32'd8);
        wb_commit();
        rs_addr = 5'd8; #1;
        check_val("alu_read", rs_data, 32'h12345678);
        check_val("alu_cnt", commit_count, 32'd1);

        wb_issue(5'd8, 2'b01, 32'h11111111, 32'hDEADBEEF, 32'h00001000);
        wb_commit();
        check_val("mem_read", rs_data, 32'hDEADBEEF);
        check_val("mem_cnt", commit_count, 32'd2);

        wb_issue(5'd8, 2'b10, 32'h11111111, 32'h22222222, 32'h00400010);
        wb_commit();
        check_val("link_read", rs_data, 32'h00400014);
        check_val("link_cnt", commit_count, 32'd3);

        // Write to $0 must be suppressed
        wb_issue(5'd0, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0);
        check_val("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check_val("r0_fwd_rd", {27'd0, fwd_rd}, 32'd0);
        check_val("r0_fwd_data", fwd_data, 32'hFFFFFFFF);
        wb_commit();
        rs_addr = 5'd0; #1;
        check_val("r0_read", rs_data, 32'd0);
        check_val("r0_cnt", commit_count, 32'd3);

        // Same-cycle read of a register being written
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        wb_issue(5'd9, 2'b00, 32'hA5A5A5A5, 32'd0, 32'd0);
        check_val("byp_fwd_valid", {31'd0, fwd_valid}, 32'd1);
`ifdef WB_BYPASS_EN
        check_val("byp_rs_same", rs_data, 32'hA5A5A5A5);
        check_val("byp_rt_same", rt_data, 32'hA5A5A5A5);
`else
        check_val("byp_rs_same", rs_data, 32'd0);
        check_val("byp_rt_same", rt_data, 32'd0);
`endif
        wb_commit();
        check_val("byp_rs_after", rs_data, 32'hA5A5A5A5);
        check_val("byp_rt_after", rt_data, 32'hA5A5A5A5);
        check_val("byp_cnt", commit_count, 32'd4);

        // Link address wraps to zero; $31 preloaded so the clear is observable
        rs_addr = 5'd31;
        wb_issue(5'd31, 2'b00, 32'h00000055, 32'd0, 32'd0);
        wb_commit();
        check_val("r31_pre", rs_data, 32'h00000055);
        wb_issue(5'd31, 2'b10, 32'h00000066, 32'h00000077, 32'hFFFFFFFC);
        check_val("wrap_fwd_data", fwd_data, 32'd0);
        wb_commit();
        check_val("wrap_read", rs_data, 32'd0);

        // Reserved selector behaves as ALU
        rt_addr = 5'd10;
        wb_issue(5'd10, 2'b11, 32'd7, 32'h00000099, 32'h00000100);
        check_val("sel11_fwd_data", fwd_data, 32'd7);
        wb_commit();
        check_val("sel11_read", rt_data, 32'd7);
        check_val("sel11_cnt", commit_count, 32'd7);

        // Overwrite $sp, then assert reset between clock edges
        rs_addr = 5'd29;
        wb_issue(5'd29, 2'b00, 32'h0000CAFE, 32'd0, 32'd0);
        wb_commit();
        check_val("sp_write", rs_data, 32'h0000CAFE);
        check_val("pre_rst_cnt", commit_count, 32'd8);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        rt_addr = 5'd8;
        #1;
        check_val("arst_sp", rs_data, 32'h000003FC);
        check_val("arst_r8", rt_data, 32'd0);
        check_val("arst_cnt", commit_count, 32'd0);
        rt_addr = 5'd10; #1;
        check_val("arst_r10", rt_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
        $finish;
    end

endmodule
